// File: rtl/reward_pkg.sv
// Shared types and constants for the reward scheduler: FSM states,
// reward type codes and the LFSR seed/tap mask.
package reward_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SHOW   = 2'd2,
    ST_EFFECT = 2'd3
  } state_t;

  localparam logic [1:0] REW_PROTECT = 2'b01;
  localparam logic [1:0] REW_GRADE   = 2'b10;
  localparam logic [1:0] REW_SLOW    = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int CNT_W = 11;

  function automatic logic [1:0] map_type(input logic [1:0] raw, input logic slow_en);
    if (raw == 2'b00) return REW_PROTECT;
    if (raw == REW_SLOW && !slow_en) return REW_PROTECT;
    return raw;
  endfunction

endpackage

// File: rtl/reward_lfsr.sv
// Free-running 16-bit Galois LFSR; a non-zero seed keeps it out of the
// all-zero lock-up state.
module reward_lfsr
  import reward_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= LFSR_SEED;
    else
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/reward_scheduler.sv
// Reward spawn/collect/effect scheduler for the snake game.
// Optional macro REWARD_SLOW_EN enables the slow-down reward type.
module reward_scheduler
  import reward_pkg::*;
#(
  parameter int SPAWN_DELAY = 300,
  parameter int LIFETIME    = 500,
  parameter int EFFECT_TIME = 1000,
  parameter int X_MAX       = 37,
  parameter int Y_MAX       = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_en,
  input  logic       tick,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  output logic       set_require,
  output logic       enable_reward,
  output logic [5:0] random_xpos,
  output logic [5:0] random_ypos,
  output logic [1:0] reward_type,
  output logic       protect_active,
  output logic       slow_active,
  output logic       grade_pulse
);

`ifdef REWARD_SLOW_EN
  localparam logic SLOW_EN = 1'b1;
`else
  localparam logic SLOW_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(SPAWN_DELAY);
  localparam logic [CNT_W-1:0] LIFE_LD   = CNT_W'(LIFETIME);
  localparam logic [CNT_W-1:0] EFFECT_LD = CNT_W'(EFFECT_TIME);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             set_n, en_n, prot_n, grade_n;
  logic [5:0]       x_n, y_n;
  logic [1:0]       type_n;
  logic [15:0]      lfsr;
  logic             collect, legal;
  logic             lfsr_unused;
`ifdef REWARD_SLOW_EN
  logic             slow_n;
`endif

  reward_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:14];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    set_n   = set_require;
    en_n    = enable_reward;
    x_n     = random_xpos;
    y_n     = random_ypos;
    type_n  = reward_type;
    prot_n  = protect_active;
    grade_n = 1'b0;
`ifdef REWARD_SLOW_EN
    slow_n  = slow_active;
`endif
    collect = (head_x == random_xpos) && (head_y == random_ypos);
    legal   = (lfsr[5:0] <= 6'(X_MAX)) && (lfsr[11:6] <= 6'(Y_MAX));

    // Dropping game_en from any active state wins over every other transition
    if (state != ST_IDLE && !game_en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      set_n   = 1'b0;
      en_n    = 1'b0;
      x_n     = '0;
      y_n     = '0;
      type_n  = '0;
      prot_n  = 1'b0;
`ifdef REWARD_SLOW_EN
      slow_n  = 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (game_en) begin
            state_n = ST_WAIT;
            cnt_n   = DELAY_LD;
            set_n   = 1'b1;
          end
        end
        // A zero counter means a rejected sample: retry every clock
        ST_WAIT: begin
          if (cnt == '0 || (tick && cnt == CNT_ONE)) begin
            if (legal) begin
              x_n     = lfsr[5:0];
              y_n     = lfsr[11:6];
              type_n  = map_type(lfsr[13:12], SLOW_EN);
              en_n    = 1'b1;
              state_n = ST_SHOW;
              cnt_n   = LIFE_LD;
            end else begin
              cnt_n = '0;
            end
          end else if (tick) begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        ST_SHOW: begin
          if (collect) begin
            en_n = 1'b0;
            if (reward_type == REW_GRADE) begin
              grade_n = 1'b1;
              state_n = ST_WAIT;
              cnt_n   = DELAY_LD;
            end else begin
              state_n = ST_EFFECT;
              cnt_n   = EFFECT_LD;
`ifdef REWARD_SLOW_EN
              if (reward_type == REW_SLOW) slow_n = 1'b1;
              else prot_n = 1'b1;
`else
              prot_n = 1'b1;
`endif
            end
          end else if (tick) begin
            if (cnt == CNT_ONE) begin
              en_n    = 1'b0;
              state_n = ST_WAIT;
              cnt_n   = DELAY_LD;
            end else begin
              cnt_n = cnt - CNT_ONE;
            end
          end
        end
        ST_EFFECT: begin
          if (tick) begin
            if (cnt == CNT_ONE) begin
              prot_n  = 1'b0;
`ifdef REWARD_SLOW_EN
              slow_n  = 1'b0;
`endif
              state_n = ST_WAIT;
              cnt_n   = DELAY_LD;
            end else begin
              cnt_n = cnt - CNT_ONE;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      set_require    <= 1'b0;
      enable_reward  <= 1'b0;
      random_xpos    <= '0;
      random_ypos    <= '0;
      reward_type    <= '0;
      protect_active <= 1'b0;
      grade_pulse    <= 1'b0;
`ifdef REWARD_SLOW_EN
      slow_active    <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      set_require    <= set_n;
      enable_reward  <= en_n;
      random_xpos    <= x_n;
      random_ypos    <= y_n;
      reward_type    <= type_n;
      protect_active <= prot_n;
      grade_pulse    <= grade_n;
`ifdef REWARD_SLOW_EN
      slow_active    <= slow_n;
`endif
    end
  end

`ifndef REWARD_SLOW_EN
  assign slow_active = 1'b0;
`endif

endmodule

// File: tb/tb_reward_scheduler.sv
// Self-checking bench for reward_scheduler: reference model plus directed
// scenarios (spawn, grade, protect, expiry, collect-vs-expiry, aborts).
module tb_reward_scheduler;

  localparam int SPAWN = 4;
  localparam int LIFE  = 8;
  localparam int EFF   = 6;
  localparam int XM    = 37;
  localparam int YM    = 25;

  localparam int PH_IDLE   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SHOW   = 2;
  localparam int PH_EFFECT = 3;

`ifdef REWARD_SLOW_EN
  localparam bit SLOW_BUILD = 1'b1;
`else
  localparam bit SLOW_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_en = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] head_x = 6'd63;
  logic [5:0] head_y = 6'd63;

  logic       set_require, enable_reward, protect_active, slow_active, grade_pulse;
  logic [5:0] random_xpos, random_ypos;
  logic [1:0] reward_type;

  int vectors = 0;
  int miscompares = 0;
  int ticks_seen = 0;
  int tick_phase = 0;

  // Reference model state
  int          m_phase = PH_IDLE;
  int          m_left = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] draw;
  int          kind;
  logic        exp_set = 0, exp_en = 0, exp_prot = 0, exp_slow = 0, exp_grade = 0;
  logic [5:0]  exp_x = 0, exp_y = 0;
  logic [1:0]  exp_type = 0;

  reward_scheduler #(
    .SPAWN_DELAY (SPAWN),
    .LIFETIME    (LIFE),
    .EFFECT_TIME (EFF),
    .X_MAX       (XM),
    .Y_MAX       (YM)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .game_en        (game_en),
    .tick           (tick),
    .head_x         (head_x),
    .head_y         (head_y),
    .set_require    (set_require),
    .enable_reward  (enable_reward),
    .random_xpos    (random_xpos),
    .random_ypos    (random_ypos),
    .reward_type    (reward_type),
    .protect_active (protect_active),
    .slow_active    (slow_active),
    .grade_pulse    (grade_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick = (tick_phase == 3);
      tick_phase = (tick_phase + 1) % 4;
    end
  end

  always @(posedge clk) if (tick) ticks_seen++;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    // x^16 + x^14 + x^13 + x^11, shifting right, feedback from bit 0
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    vectors++;
    if (actual < lo || actual > hi) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, actual, lo, hi, $time);
    end
  endtask

  // Reference model: phase + ticks remaining, advanced once per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = PH_IDLE; m_left = 0; m_lfsr = 16'hACE1;
      exp_set = 0; exp_en = 0; exp_x = 0; exp_y = 0; exp_type = 0;
      exp_prot = 0; exp_slow = 0; exp_grade = 0;
    end else begin
      draw = m_lfsr;
      exp_grade = 0;
      if (m_phase != PH_IDLE && !game_en) begin
        m_phase = PH_IDLE; m_left = 0;
        exp_set = 0; exp_en = 0; exp_x = 0; exp_y = 0; exp_type = 0;
        exp_prot = 0; exp_slow = 0;
      end else if (m_phase == PH_IDLE) begin
        if (game_en) begin m_phase = PH_WAIT; m_left = SPAWN; exp_set = 1; end
      end else if (m_phase == PH_WAIT) begin
        if (m_left == 0 || (tick && m_left == 1)) begin
          if (int'(draw[5:0]) <= XM && int'(draw[11:6]) <= YM) begin
            kind = int'(draw[13:12]);
            if (kind == 0) kind = 1;
            if (kind == 3 && !SLOW_BUILD) kind = 1;
            exp_x = draw[5:0]; exp_y = draw[11:6]; exp_type = 2'(kind);
            exp_en = 1; m_phase = PH_SHOW; m_left = LIFE;
          end else m_left = 0;
        end else if (tick) m_left--;
      end else if (m_phase == PH_SHOW) begin
        if (head_x == exp_x && head_y == exp_y) begin
          exp_en = 0;
          if (exp_type == 2'b10) begin exp_grade = 1; m_phase = PH_WAIT; m_left = SPAWN; end
          else begin
            if (exp_type == 2'b11) exp_slow = 1; else exp_prot = 1;
            m_phase = PH_EFFECT; m_left = EFF;
          end
        end else if (tick) begin
          m_left--;
          if (m_left == 0) begin exp_en = 0; m_phase = PH_WAIT; m_left = SPAWN; end
        end
      end else begin
        if (tick) begin
          m_left--;
          if (m_left == 0) begin exp_prot = 0; exp_slow = 0; m_phase = PH_WAIT; m_left = SPAWN; end
        end
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    checkOutput("outputs",
      32'({set_require, enable_reward, random_xpos, random_ypos, reward_type, protect_active, slow_active, grade_pulse}),
      32'({exp_set, exp_en, exp_x, exp_y, exp_type, exp_prot, exp_slow, exp_grade}));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] hx, input logic [5:0] hy);
    game_en = en; head_x = hx; head_y = hy;
    step();
  endtask

  task automatic waitSpawn();
    for (int i = 0; i < 400; i++) begin
      if (exp_en) return;
      step();
    end
    checkOutput("spawn_timeout", 32'(0), 32'(1));
  endtask

  task automatic collectNow();
    applyStimulus(1'b1, exp_x, exp_y);
    head_x = 6'd63; head_y = 6'd63;
  endtask

  task automatic findReward(input logic [1:0] want, output bit ok);
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      waitSpawn();
      if (exp_type == want) begin ok = 1; return; end
      collectNow();
    end
    checkOutput("find_reward_type", 32'(0), 32'(1));
  endtask

  task automatic ticksUntil(input logic level, output int n);
    int start;
    start = ticks_seen;
    for (int i = 0; i < 400; i++) begin
      if (enable_reward == level) begin n = ticks_seen - start; return; end
      step();
    end
    n = -1;
  endtask

  initial begin
    int  n, start;
    bit  ok;
    logic [1:0] k;
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  n, start;
    bit  ok;
    logic [1:0] k;
    $display("[TB] reward_scheduler bench start");
    repeat (3) step();
    checkOutput("reset_outputs", 32'({set_require, enable_reward, protect_active, grade_pulse}), 32'(0));
    checkOutput("reset_lfsr_seed", 32'(dut.u_lfsr.state), 32'h0000ACE1);
    rst_n = 1'b1;
    step();
    checkOutput("idle_set_require", 32'(set_require), 32'(0));

    // Arm and first spawn
    applyStimulus(1'b1, 6'd63, 6'd63);
    checkOutput("set_require_after_en", 32'(set_require), 32'(1));
    checkOutput("no_reward_at_arm", 32'(enable_reward), 32'(0));
    ticksUntil(1'b1, n);
    checkRange("ticks_to_first_spawn", n, SPAWN, 60);
    checkRange("first_xpos", int'(random_xpos), 0, XM);
    checkRange("first_ypos", int'(random_ypos), 0, YM);

    // Grade collect
    findReward(2'b10, ok);
    if (ok) begin
      collectNow();
      checkOutput("grade_pulse_high", 32'(grade_pulse), 32'(1));
      checkOutput("grade_clears_reward", 32'(enable_reward), 32'(0));
      start = ticks_seen;
      step();
      checkOutput("grade_pulse_one_clk", 32'(grade_pulse), 32'(0));
      n = ticks_seen - start;
      ticksUntil(1'b1, start);
      checkRange("ticks_after_grade", n + start, SPAWN, 60);
    end

    // Protect collect: effect lasts exactly EFF ticks
    findReward(2'b01, ok);
    if (ok) begin
      collectNow();
      checkOutput("protect_set", 32'(protect_active), 32'(1));
      start = ticks_seen;
      for (int i = 0; i < 200 && protect_active; i++) step();
      checkOutput("protect_ticks", 32'(ticks_seen - start), 32'(EFF));
      checkOutput("no_spawn_in_effect", 32'(enable_reward), 32'(0));
      ticksUntil(1'b1, n);
      checkRange("ticks_after_effect", n, SPAWN, 60);
    end

    // Lifetime expiry with no collect
    waitSpawn();
    ticksUntil(1'b0, n);
    checkOutput("lifetime_ticks", 32'(n), 32'(LIFE));

    // Collect on the same clock as the expiry tick
    waitSpawn();
    for (int i = 0; i < 200 && !(tick && m_left == 1 && m_phase == PH_SHOW); i++) step();
    k = exp_type;
    collectNow();
    checkOutput("collect_beats_expiry",
      32'({enable_reward, grade_pulse, protect_active | slow_active}),
      (k == 2'b10) ? 32'b010 : 32'b001);

    // game_en drop during an effect
    findReward(2'b01, ok);
    if (ok) begin
      collectNow();
      step(); step();
      applyStimulus(1'b0, 6'd63, 6'd63);
      checkOutput("abort_effect_outputs",
        32'({set_require, enable_reward, random_xpos, random_ypos, reward_type, protect_active, slow_active, grade_pulse}), 32'(0));
      applyStimulus(1'b1, 6'd63, 6'd63);
    end

    // Async reset while a reward is shown
    waitSpawn();
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_show_outputs",
      32'({set_require, enable_reward, random_xpos, random_ypos, reward_type, protect_active, slow_active, grade_pulse}), 32'(0));
    checkOutput("reset_mid_show_lfsr", 32'(dut.u_lfsr.state), 32'h0000ACE1);
    step();
    rst_n = 1'b1;
    step();

    // Long run of spawns
    for (int i = 0; i < 200; i++) begin
      waitSpawn();
`ifndef REWARD_SLOW_EN
      checkOutput("type_never_slow", 32'(reward_type == 2'b11), 32'(0));
      checkOutput("slow_never_active", 32'(slow_active), 32'(0));
`endif
      collectNow();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
